// File: rtl/alarm_arm_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alarm_arm_ctrl : input sync/debounce plus arming FSM for the home alarm.
// Option ALARM_AUTO_RESET_EN: ALARM falls back to ARMED after a quiet hold.
// Rev 1.0
// ----------------------------------------------------------------------------
module alarm_arm_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned TICK_CYCLES     = 100_000_000,
  parameter int unsigned EXIT_SEC        = 9,
  parameter int unsigned ENTRY_SEC       = 5,
  parameter int unsigned ALARM_HOLD_SEC  = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       master_sw,
  input  logic [3:0] sensor_sw,
  output logic       armed,
  output logic       exit_pending,
  output logic       alarm,
  output logic [3:0] zone_latched,
  output logic [3:0] countdown
);

  localparam int unsigned NIN  = 5;
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PS_W = $clog2(TICK_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_ALARM    = 3'd4
  } state_t;

  if (EXIT_SEC > 15 || ENTRY_SEC > 15 || ALARM_HOLD_SEC < 1 || ALARM_HOLD_SEC > 15) begin : g_param_check
    $error("alarm_arm_ctrl: seconds parameter out of range");
  end

  // Bit 0 is the master switch, bits 4:1 are the sensors.
  logic [NIN-1:0] raw_in;
  logic [NIN-1:0] sync1_q, sync2_q, db_q, db_d;

  assign raw_in = {sensor_sw, master_sw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      db_q    <= db_d;
    end
  end

  for (genvar gi = 0; gi < NIN; gi++) begin : g_debounce
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            bit_d;

    // The counter only runs while the synced sample disagrees with the debounced value.
    always_comb begin
      cnt_d = '0;
      bit_d = db_q[gi];
      if (sync2_q[gi] != db_q[gi]) begin
        if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          bit_d = sync2_q[gi];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign db_d[gi] = bit_d;
  end

  logic       master_db;
  logic [3:0] sens_db;

  assign master_db = db_q[0];
  assign sens_db   = db_q[4:1];

  state_t            state_q, state_d;
  logic [3:0]        zone_q, zone_d;
  logic [3:0]        cd_q, cd_d;
  logic [PS_W-1:0]   presc_q, presc_d;
  logic              tick;
  logic              presc_restart;

  assign tick = (presc_q == PS_W'(TICK_CYCLES - 1));

`ifdef ALARM_AUTO_RESET_EN
  logic [3:0] hold_q, hold_d;
`endif

  always_comb begin
    state_d = state_q;
    zone_d  = zone_q;
    cd_d    = cd_q;
`ifdef ALARM_AUTO_RESET_EN
    hold_d  = '0;
`endif
    if (!master_db) begin
      state_d = ST_DISARMED;
      zone_d  = '0;
      cd_d    = '0;
    end else begin
      case (state_q)
        ST_DISARMED: begin
          if (EXIT_SEC == 0) begin
            state_d = ST_ARMED;
            cd_d    = '0;
          end else begin
            state_d = ST_EXIT;
            cd_d    = 4'(EXIT_SEC);
          end
        end
        ST_EXIT: begin
          if (tick) begin
            if (cd_q <= 4'd1) begin
              state_d = ST_ARMED;
              cd_d    = '0;
            end else begin
              cd_d = cd_q - 4'd1;
            end
          end
        end
        ST_ARMED: begin
          if (|sens_db[3:1]) begin
            state_d = ST_ALARM;
            zone_d  = zone_q | sens_db;
            cd_d    = '0;
          end else if (sens_db[0]) begin
            zone_d[0] = 1'b1;
            if (ENTRY_SEC == 0) begin
              state_d = ST_ALARM;
              cd_d    = '0;
            end else begin
              state_d = ST_ENTRY;
              cd_d    = 4'(ENTRY_SEC);
            end
          end
        end
        ST_ENTRY: begin
          zone_d = zone_q | sens_db;
          if (|sens_db[3:1]) begin
            state_d = ST_ALARM;
            cd_d    = '0;
          end else if (tick) begin
            if (cd_q <= 4'd1) begin
              state_d = ST_ALARM;
              cd_d    = '0;
            end else begin
              cd_d = cd_q - 4'd1;
            end
          end
        end
        ST_ALARM: begin
          zone_d = zone_q | sens_db;
          cd_d   = '0;
`ifdef ALARM_AUTO_RESET_EN
          if (|sens_db) begin
            hold_d = '0;
          end else if (tick) begin
            if (hold_q >= 4'(ALARM_HOLD_SEC - 1)) begin
              state_d = ST_ARMED;
              hold_d  = '0;
            end else begin
              hold_d = hold_q + 4'd1;
            end
          end else begin
            hold_d = hold_q;
          end
`endif
        end
        default: begin
          state_d = ST_DISARMED;
          zone_d  = '0;
          cd_d    = '0;
        end
      endcase
    end
  end

  // Each timed state starts a whole second; a live sensor in ALARM also rewinds the second.
  always_comb begin
    presc_restart = (state_d != state_q) &&
                    (state_d inside {ST_EXIT, ST_ENTRY, ST_ALARM});
`ifdef ALARM_AUTO_RESET_EN
    if (state_q == ST_ALARM && state_d == ST_ALARM && (|sens_db)) begin
      presc_restart = 1'b1;
    end
`endif
    if (presc_restart || tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  logic armed_q, armed_d;
  logic exit_q, exit_d;
  logic alarm_q, alarm_d;

  always_comb begin
    armed_d = (state_d inside {ST_ARMED, ST_ENTRY, ST_ALARM});
    exit_d  = (state_d == ST_EXIT);
    alarm_d = (state_d == ST_ALARM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_DISARMED;
      zone_q  <= '0;
      cd_q    <= '0;
      presc_q <= '0;
      armed_q <= 1'b0;
      exit_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      zone_q  <= zone_d;
      cd_q    <= cd_d;
      presc_q <= presc_d;
      armed_q <= armed_d;
      exit_q  <= exit_d;
      alarm_q <= alarm_d;
    end
  end

`ifdef ALARM_AUTO_RESET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  assign armed        = armed_q;
  assign exit_pending = exit_q;
  assign alarm        = alarm_q;
  assign zone_latched = zone_q;
  assign countdown    = cd_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_arm_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alarm_arm_ctrl : scoreboard bench for alarm_arm_ctrl (small timing params).
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_alarm_arm_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       master_sw = 1'b0;
  logic [3:0] sensor_sw = 4'b0000;
  logic       armed, exit_pending, alarm;
  logic [3:0] zone_latched, countdown;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    string       nm;
    logic [10:0] exp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  alarm_arm_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TICK_CYCLES    (10),
    .EXIT_SEC       (3),
    .ENTRY_SEC      (2),
    .ALARM_HOLD_SEC (2)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .master_sw   (master_sw),
    .sensor_sw   (sensor_sw),
    .armed       (armed),
    .exit_pending(exit_pending),
    .alarm       (alarm),
    .zone_latched(zone_latched),
    .countdown   (countdown)
  );

  function automatic logic [10:0] pk(input logic a, input logic e, input logic al,
                                     input logic [3:0] z, input logic [3:0] c);
    return {a, e, al, z, c};
  endfunction

  function automatic logic [10:0] obs();
    return {armed, exit_pending, alarm, zone_latched, countdown};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input int due, input string nm, input logic [10:0] e);
    exp_t x;
    x.due = due;
    x.nm  = nm;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic arm();
    master_sw = 1'b1;
    sensor_sw = 4'b0000;
    repeat (40) step();
  endtask

  task automatic disarm_quiet();
    master_sw = 1'b0;
    sensor_sw = 4'b0000;
    repeat (10) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    vectors++;
    if (obs() !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_hold: got %b want %b", obs(), 11'd0);
    end
    rst_n = 1'b1;
    repeat (3) step();
    vectors++;
    if (obs() !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_release: got %b want %b", obs(), 11'd0);
    end
  endtask

  task automatic test_bounce();
    int k = cyc;
    for (int c = 1; c <= 40; c++) push(k + c, "bounce", pk(0, 0, 0, 4'h0, 4'h0));
    for (int c = 0; c < 40; c++) begin
      master_sw = (c < 36) && (((c / 3) % 2) == 0);
      step();
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e = sb.pop_front();
        vectors++;
        if (obs() !== e.exp) begin
          miscompares++;
          $display("FAIL %s cycle %0d: got %b want %b", e.nm, cyc, obs(), e.exp);
        end
      end
    end
  endtask

  task automatic test_exit_delay();
    int k = cyc;
    for (int c = 1; c <= 42; c++) begin
      if (c < 7)       push(k + c, "exit_pre", pk(0, 0, 0, 4'h0, 4'h0));
      else if (c < 37) push(k + c, "exit_cd", pk(0, 1, 0, 4'h0, 4'(3 - (c - 7) / 10)));
      else             push(k + c, "exit_armed", pk(1, 0, 0, 4'h0, 4'h0));
    end
    master_sw = 1'b1;
    for (int c = 0; c < 42; c++) begin
      step();
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e = sb.pop_front();
        vectors++;
        if (obs() !== e.exp) begin
          miscompares++;
          $display("FAIL %s cycle %0d: got %b want %b", e.nm, cyc, obs(), e.exp);
        end
      end
    end
  endtask

  task automatic test_instant_zone();
    int k = cyc;
    for (int c = 1; c <= 12; c++)
      push(k + c, "inst_a", (c < 7) ? pk(1, 0, 0, 4'h0, 4'h0) : pk(1, 0, 1, 4'b0100, 4'h0));
    for (int c = 13; c <= 24; c++)
      push(k + c, "inst_b", (c < 19) ? pk(1, 0, 1, 4'b0100, 4'h0) : pk(1, 0, 1, 4'b1100, 4'h0));
    for (int c = 25; c <= 36; c++)
      push(k + c, "disarm", (c < 31) ? pk(1, 0, 1, 4'b1100, 4'h0) : pk(0, 0, 0, 4'h0, 4'h0));
    for (int c = 0; c < 36; c++) begin
      if (c == 0)  sensor_sw = 4'b0100;
      if (c == 12) sensor_sw = 4'b1000;
      if (c == 24) begin
        master_sw = 1'b0;
        sensor_sw = 4'b0000;
      end
      step();
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e = sb.pop_front();
        vectors++;
        if (obs() !== e.exp) begin
          miscompares++;
          $display("FAIL %s cycle %0d: got %b want %b", e.nm, cyc, obs(), e.exp);
        end
      end
    end
  endtask

  task automatic test_entry_delay();
    int k;
    arm();
    k = cyc;
    for (int c = 1; c <= 30; c++) begin
      if (c < 7)       push(k + c, "entry_pre", pk(1, 0, 0, 4'h0, 4'h0));
      else if (c < 17) push(k + c, "entry_cd2", pk(1, 0, 0, 4'b0001, 4'd2));
      else if (c < 27) push(k + c, "entry_cd1", pk(1, 0, 0, 4'b0001, 4'd1));
      else             push(k + c, "entry_alarm", pk(1, 0, 1, 4'b0001, 4'd0));
    end
    sensor_sw = 4'b0001;
    for (int c = 0; c < 30; c++) begin
      step();
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e = sb.pop_front();
        vectors++;
        if (obs() !== e.exp) begin
          miscompares++;
          $display("FAIL %s cycle %0d: got %b want %b", e.nm, cyc, obs(), e.exp);
        end
      end
    end
    disarm_quiet();
  endtask

  task automatic test_entry_cancel();
    int k;
    arm();
    k = cyc;
    for (int c = 1; c <= 30; c++) begin
      if (c < 7)       push(k + c, "cancel_pre", pk(1, 0, 0, 4'h0, 4'h0));
      else if (c < 17) push(k + c, "cancel_cd", pk(1, 0, 0, 4'b0001, 4'd2));
      else             push(k + c, "cancel_off", pk(0, 0, 0, 4'h0, 4'h0));
    end
    sensor_sw = 4'b0001;
    for (int c = 0; c < 30; c++) begin
      if (c == 10) master_sw = 1'b0;
      step();
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e = sb.pop_front();
        vectors++;
        if (obs() !== e.exp) begin
          miscompares++;
          $display("FAIL %s cycle %0d: got %b want %b", e.nm, cyc, obs(), e.exp);
        end
      end
    end
    disarm_quiet();
  endtask

  task automatic test_back_to_back();
    int k;
    arm();
    k = cyc;
    for (int c = 1; c <= 10; c++)
      push(k + c, "both_zones", (c < 7) ? pk(1, 0, 0, 4'h0, 4'h0) : pk(1, 0, 1, 4'b0011, 4'h0));
    sensor_sw = 4'b0011;
    for (int c = 0; c < 10; c++) begin
      step();
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e = sb.pop_front();
        vectors++;
        if (obs() !== e.exp) begin
          miscompares++;
          $display("FAIL %s cycle %0d: got %b want %b", e.nm, cyc, obs(), e.exp);
        end
      end
    end
    disarm_quiet();
  endtask

  task automatic test_alarm_hold();
    int k;
`ifdef ALARM_AUTO_RESET_EN
    int n = 40;
`else
    int n = 120;
`endif
    arm();
    k = cyc;
    for (int c = 1; c <= n; c++) begin
      if (c < 7) push(k + c, "hold_pre", pk(1, 0, 0, 4'h0, 4'h0));
`ifdef ALARM_AUTO_RESET_EN
      else if (c < 34) push(k + c, "hold_alarm", pk(1, 0, 1, 4'b0100, 4'h0));
      else             push(k + c, "hold_rearm", pk(1, 0, 0, 4'b0100, 4'h0));
`else
      else push(k + c, "hold_alarm", pk(1, 0, 1, 4'b0100, 4'h0));
`endif
    end
    sensor_sw = 4'b0100;
    for (int c = 0; c < n; c++) begin
      if (c == 8) sensor_sw = 4'b0000;
      step();
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e = sb.pop_front();
        vectors++;
        if (obs() !== e.exp) begin
          miscompares++;
          $display("FAIL %s cycle %0d: got %b want %b", e.nm, cyc, obs(), e.exp);
        end
      end
    end
    disarm_quiet();
  endtask

  task automatic test_reset_mid();
    arm();
    sensor_sw = 4'b0010;
    repeat (8) step();
    vectors++;
    if (obs() !== pk(1, 0, 1, 4'b0010, 4'h0)) begin
      miscompares++;
      $display("FAIL mid_alarm: got %b want %b", obs(), pk(1, 0, 1, 4'b0010, 4'h0));
    end
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (obs() !== 11'd0) begin
      miscompares++;
      $display("FAIL mid_async_reset: got %b want %b", obs(), 11'd0);
    end
    master_sw = 1'b0;
    sensor_sw = 4'b0000;
    step();
    rst_n = 1'b1;
    repeat (10) step();
    vectors++;
    if (obs() !== 11'd0) begin
      miscompares++;
      $display("FAIL mid_after_release: got %b want %b", obs(), 11'd0);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_exit_delay();
    test_instant_zone();
    test_entry_delay();
    test_entry_cancel();
    test_back_to_back();
    test_alarm_hold();
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
